// File: rtl/fetch_unit.sv
// fetch_unit: RV32I instruction fetch stage.
// Owns the fetch PC. Requests are issued in order over a valid/ready channel.
// Responses come back in the same order. They are buffered in a small FIFO
// and handed to decode with a valid/stall handshake. A redirect flushes the
// FIFO and marks every request still in flight as stale.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   imem_req_valid/ready  fetch request handshake
//   imem_req_addr         word-aligned fetch address
//   imem_rsp_valid/data   in-order response (no backpressure)
//   redirect_valid/pc     taken branch / jump target
//   stall                 decode not accepting
//   if_valid/instruction/pc  FIFO head presented to decode
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        if_valid,
  output logic [31:0] if_instruction,
  output logic [31:0] if_pc
);

  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fentry_t;

  fentry_t       fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, outstanding, drop;
  logic [31:0]   fetch_pc, rsp_pc;

  logic          cap_ok, req_fire, discard, push, pop;
  logic [CW:0]   inflight;
  logic [31:0]   redirect_al;
  fentry_t       head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Buffered plus in-flight fetches never exceed FIFO_DEPTH, so every
  // response always has a FIFO slot waiting for it.
  assign inflight       = {1'b0, outstanding} + {1'b0, count};
  assign cap_ok         = inflight < (CW+1)'(FIFO_DEPTH);
  assign imem_req_valid = cap_ok && !redirect_valid && rst_n;
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Stale responses are those still owed from before a redirect, plus any
  // response that lands in the same cycle as a redirect.
  assign discard     = (drop != '0) || redirect_valid;
  assign push        = imem_rsp_valid && !discard;
  assign if_valid    = (count != '0);
  assign pop         = if_valid && !stall && !redirect_valid;
  assign redirect_al = {redirect_pc[31:2], 2'b00};

  assign head           = fifo_q[rd_ptr];
  assign if_instruction = if_valid ? head.instr : NOP;
  assign if_pc          = if_valid ? head.pc    : 32'h0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop        <= '0;
      count       <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      // No request is issued during a redirect, so req_fire is 0 then.
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        fetch_pc <= redirect_al;
        rsp_pc   <= redirect_al;
        drop     <= outstanding - CW'(imem_rsp_valid);
        count    <= '0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
      end else begin
        if (req_fire)                       fetch_pc <= fetch_pc + 32'd4;
        if (imem_rsp_valid && drop != '0)   drop     <= drop - 1'b1;
        if (push) begin
          rsp_pc <= rsp_pc + 32'd4;
          wr_ptr <= ptr_inc(wr_ptr);
        end
        if (pop) rd_ptr <= ptr_inc(rd_ptr);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Payload storage needs no reset; occupancy is tracked by count.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{pc: rsp_pc, instr: imem_rsp_data};
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && count == CW'(FIFO_DEPTH)));
  a_rsp_owed: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && outstanding == '0));

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit. An in-order memory model answers one cycle after each
// accepted request. It can hold responses to build up in-flight requests.
// The stimulus pushes the expected PC stream into a queue. A negedge monitor
// pops one entry for every instruction decode consumes and compares it.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        if_valid;
  logic [31:0] if_instruction, if_pc;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .stall(stall),
    .if_valid(if_valid), .if_instruction(if_instruction), .if_pc(if_pc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int consumed = 0;
  logic mon_en = 1'b0;
  logic hold = 1'b0;
  logic [31:0] exp_q[$];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  // In-order memory model
  logic [31:0] maddr [8];
  logic [2:0]  mh, mt;
  logic [3:0]  mc;
  assign imem_rsp_valid = (mc != 4'd0) && !hold;
  assign imem_rsp_data  = imem_rsp_valid ? mem_f(maddr[mh]) : 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mh <= 3'd0; mt <= 3'd0; mc <= 4'd0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        maddr[mt] <= imem_req_addr;
        mt <= mt + 3'd1;
      end
      if (imem_rsp_valid) mh <= mh + 3'd1;
      mc <= mc + 4'(imem_req_valid && imem_req_ready) - 4'(imem_rsp_valid);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_seq(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (if_valid && !stall && !redirect_valid) begin
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_instr: got pc %h, expected none", if_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          check("if_pc", if_pc, e);
          check("if_instruction", if_instruction, mem_f(e));
          consumed++;
        end
      end else if (!if_valid) begin
        check("idle_instr_nop", if_instruction, 32'h0000_0013);
        check("idle_pc_zero", if_pc, 32'h0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  int c0;
  logic [31:0] a0;
  logic seen;

  initial begin
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    #2;
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_req_addr", imem_req_addr, 32'h0);
    check("rst_if_valid", 32'(if_valid), 32'd0);
    check("rst_instr", if_instruction, 32'h0000_0013);
    check("rst_pc", if_pc, 32'h0);

    // Startup: request in cycle 1, response in 2, visible to decode in 3
    push_seq(32'h0, 64);
    mon_en = 1'b1;
    @(negedge clk); rst_n = 1'b1; #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_req_addr, 32'h0);
    cyc(1);
    check("cycle2_if_valid", 32'(if_valid), 32'd0);
    cyc(1);
    check("cycle3_if_valid", 32'(if_valid), 32'd1);
    check("cycle3_if_pc", if_pc, 32'h0);
    c0 = consumed;
    cyc(20);
    check("flow_progress", 32'(consumed - c0 >= 8), 32'd1);

    // Stall: buffer fills, issue stops, nothing popped
    stall = 1'b1; c0 = consumed;
    cyc(5);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_if_valid", 32'(if_valid), 32'd1);
    check("stall_no_pop", 32'(consumed), 32'(c0));
    stall = 1'b0;
    // Exactly two entries were held: two valid cycles, then a bubble
    check("release0_valid", 32'(if_valid), 32'd1);
    cyc(1);
    check("release1_valid", 32'(if_valid), 32'd1);
    cyc(1);
    check("release2_valid", 32'(if_valid), 32'd0);
    cyc(8);

    // Memory not ready: address frozen, decode drains
    imem_req_ready = 1'b0; a0 = imem_req_addr;
    for (int i = 0; i < 4; i++) begin
      cyc(1);
      check("notready_addr_held", imem_req_addr, a0);
    end
    check("notready_drained", 32'(if_valid), 32'd0);
    imem_req_ready = 1'b1;
    cyc(10);

    // Redirect with two requests in flight; low PC bits are ignored
    hold = 1'b1;
    cyc(4);
    check("two_in_flight", 32'(mc), 32'd2);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    exp_q.delete(); push_seq(32'h100, 64);
    #1;
    check("redirect_no_req", 32'(imem_req_valid), 32'd0);
    cyc(1);
    redirect_valid = 1'b0; hold = 1'b0;
    #1;
    check("redirect_if_valid0", 32'(if_valid), 32'd0);
    check("redirect_addr", imem_req_addr, 32'h100);
    c0 = consumed;
    cyc(15);
    check("redirect_progress", 32'(consumed - c0 >= 5), 32'd1);

    // Redirect + stall with a response landing the same cycle
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      if (imem_rsp_valid) seen = 1'b1;
      else cyc(1);
    end
    check("rsp_seen_for_redirect", 32'(seen), 32'd1);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200; stall = 1'b1;
    exp_q.delete(); push_seq(32'h200, 64);
    cyc(1);
    redirect_valid = 1'b0; stall = 1'b0;
    #1;
    check("redir_stall_empty", 32'(if_valid), 32'd0);
    c0 = consumed;
    cyc(15);
    check("redir_stall_progress", 32'(consumed - c0 >= 5), 32'd1);

    // PC wrap past 0xFFFF_FFFC
    cyc(1);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF8;
    exp_q.delete(); push_seq(32'hFFFF_FFF8, 64);
    cyc(1);
    redirect_valid = 1'b0;
    c0 = consumed;
    cyc(15);
    check("wrap_progress", 32'(consumed - c0 >= 5), 32'd1);

    // Async reset with two requests outstanding
    hold = 1'b1;
    cyc(4);
    check("reset_two_in_flight", 32'(mc), 32'd2);
    rst_n = 1'b0;
    #1;
    check("midrst_req_valid", 32'(imem_req_valid), 32'd0);
    check("midrst_req_addr", imem_req_addr, 32'h0);
    check("midrst_if_valid", 32'(if_valid), 32'd0);
    check("midrst_instr", if_instruction, 32'h0000_0013);
    check("midrst_pc", if_pc, 32'h0);
    hold = 1'b0;
    exp_q.delete(); push_seq(32'h0, 64);
    @(negedge clk); rst_n = 1'b1; #1;
    check("restart_req_valid", 32'(imem_req_valid), 32'd1);
    check("restart_req_addr", imem_req_addr, 32'h0);
    c0 = consumed;
    cyc(15);
    check("restart_progress", 32'(consumed - c0 >= 5), 32'd1);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
